// File: rtl/mfhwt_line_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// mfhwt_line_wr_ctrl_if
// Purpose : Bundles the pixel-input handshake, the write/read side of the
//           4-row line FIFO bank and the downstream column handshake used by
//           mfhwt_line_wr_ctrl.
// Signals :
//   iValid, iSof, iData[15:0]  - upstream pixel stream (iSof qualified by iValid)
//   oReady                     - controller accepts a pixel this cycle
//   oWrreq[3:0], oData[15:0]   - one-hot row write request and write data
//   iFull[3:0], iEmpty         - per-row full flags, bank all-empty flag
//   oRdreq                     - common read request to all four FIFOs
//   iDsReady                   - downstream can take a 4-row column
//   oColValid                  - FIFO output holds a valid column this cycle
//   oGroupDone                 - one-cycle pulse when a 4-row group is drained
// Modports: slave  - the controller's view
//           master - the environment's view (upstream, FIFO bank, downstream)
// -----------------------------------------------------------------------------
interface mfhwt_line_wr_ctrl_if;
    logic        iValid;
    logic        iSof;
    logic [15:0] iData;
    logic        oReady;
    logic [3:0]  oWrreq;
    logic [15:0] oData;
    logic [3:0]  iFull;
    logic        iEmpty;
    logic        oRdreq;
    logic        iDsReady;
    logic        oColValid;
    logic        oGroupDone;

    modport slave (
        input  iValid, iSof, iData, iFull, iEmpty, iDsReady,
        output oReady, oWrreq, oData, oRdreq, oColValid, oGroupDone
    );

    modport master (
        output iValid, iSof, iData, iFull, iEmpty, iDsReady,
        input  oReady, oWrreq, oData, oRdreq, oColValid, oGroupDone
    );
endinterface

// File: rtl/mfhwt_line_wr_ctrl.sv
// -----------------------------------------------------------------------------
// mfhwt_line_wr_ctrl
// Purpose : Writes a raster pixel stream into a bank of four line FIFOs, one
//           row per FIFO. After four complete rows (a group) it stops taking
//           pixels and drains the bank column by column to the downstream
//           stage, then returns to filling.
// Ports   :
//   iClk        - clock, all registers rising-edge
//   iReset      - synchronous, active-high reset
//   bus         - mfhwt_line_wr_ctrl_if.slave (pixel in, FIFO bank, downstream)
//   oOverflow   - sticky "a pixel was dropped on a full FIFO" flag; exists only
//                 when MFHWT_LINE_WR_CTRL_OVF_EN is defined
// Parameters:
//   LINE_W      - pixels per row, also the depth of each line FIFO
//   CNT_W       - column counter width, 2**CNT_W >= LINE_W
// Configuration macro: MFHWT_LINE_WR_CTRL_OVF_EN (adds oOverflow)
// -----------------------------------------------------------------------------
module mfhwt_line_wr_ctrl #(
    parameter int LINE_W = 640,
    parameter int CNT_W  = 10
) (
    input  logic                  iClk,
    input  logic                  iReset,
    mfhwt_line_wr_ctrl_if.slave   bus
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
    ,
    output logic                  oOverflow
`endif
);

    // The read counter must be able to hold LINE_W itself (terminal value),
    // so it carries one bit more than the column counter.
    localparam int                RD_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(LINE_W - 1);
    localparam logic [RD_W-1:0]   RD_END   = RD_W'(LINE_W);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e            state_q,      state_d;
    logic [1:0]        row_q,        row_d;
    logic [CNT_W-1:0]  col_q,        col_d;
    logic [RD_W-1:0]   rdcnt_q,      rdcnt_d;
    logic              ready_q,      ready_d;
    logic [3:0]        wrreq_q,      wrreq_d;
    logic [15:0]       data_q,       data_d;
    logic              colvalid_q,   colvalid_d;
    logic              groupdone_q,  groupdone_d;
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
    logic              ovf_q,        ovf_d;
`endif

    logic              accept_s;
    logic              rdreq_s;
    logic              drop_s;
    logic [1:0]        eff_row_s;
    logic [CNT_W-1:0]  eff_col_s;

    // Pixel accept and effective write position; an accepted iSof relocates
    // the current pixel to the start of the group (row 0, col 0).
    always_comb begin
        accept_s  = bus.iValid && ready_q;
        if (bus.iSof) begin
            eff_row_s = 2'd0;
            eff_col_s = '0;
        end else begin
            eff_row_s = row_q;
            eff_col_s = col_q;
        end
        drop_s = accept_s && bus.iFull[eff_row_s];
    end

    // Column read request; must be 0 while reset is asserted, even mid-drain.
    always_comb begin
        rdreq_s = (state_q == ST_DRAIN) && !iReset && bus.iDsReady &&
                  !bus.iEmpty && (rdcnt_q < RD_END);
    end

    // Next-state logic for the FILL/DRAIN controller and its outputs.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rdcnt_d     = rdcnt_q;
        ready_d     = ready_q;
        wrreq_d     = 4'b0000;
        data_d      = data_q;
        colvalid_d  = rdreq_s;
        groupdone_d = 1'b0;
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
        ovf_d       = ovf_q | drop_s;
`endif
        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    data_d = bus.iData;
                    // A full row FIFO loses the pixel but the position still
                    // advances so the raster geometry stays intact.
                    if (drop_s) begin
                        wrreq_d = 4'b0000;
                    end else begin
                        wrreq_d = 4'b0001 << eff_row_s;
                    end
                    if (eff_col_s == COL_LAST) begin
                        col_d = '0;
                        row_d = eff_row_s + 2'd1;
                        if (eff_row_s == 2'd3) begin
                            state_d = ST_DRAIN;
                            ready_d = 1'b0;
                            rdcnt_d = '0;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        col_d = eff_col_s + CNT_W'(1);
                        row_d = eff_row_s;
                    end
                end else begin
                    wrreq_d = 4'b0000;
                end
            end
            ST_DRAIN: begin
                if (rdreq_s) begin
                    rdcnt_d = rdcnt_q + RD_W'(1);
                end else if (rdcnt_q == RD_END) begin
                    // All reads issued and none in flight this cycle: the
                    // last column is on the FIFO output now, leave next edge.
                    state_d     = ST_FILL;
                    ready_d     = 1'b1;
                    row_d       = 2'd0;
                    col_d       = '0;
                    rdcnt_d     = '0;
                    groupdone_d = 1'b1;
                end else begin
                    rdcnt_d = rdcnt_q;
                end
            end
            default: begin
                state_d = ST_FILL;
                ready_d = 1'b1;
                row_d   = 2'd0;
                col_d   = '0;
                rdcnt_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q     <= ST_FILL;
            row_q       <= 2'd0;
            col_q       <= '0;
            rdcnt_q     <= '0;
            ready_q     <= 1'b1;
            wrreq_q     <= 4'b0000;
            data_q      <= 16'h0000;
            colvalid_q  <= 1'b0;
            groupdone_q <= 1'b0;
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rdcnt_q     <= rdcnt_d;
            ready_q     <= ready_d;
            wrreq_q     <= wrreq_d;
            data_q      <= data_d;
            colvalid_q  <= colvalid_d;
            groupdone_q <= groupdone_d;
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.oReady     = ready_q;
    assign bus.oWrreq     = wrreq_q;
    assign bus.oData      = data_q;
    assign bus.oRdreq     = rdreq_s;
    assign bus.oColValid  = colvalid_q;
    assign bus.oGroupDone = groupdone_q;
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
    assign oOverflow      = ovf_q;
`endif

endmodule

// File: tb/tb_mfhwt_line_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mfhwt_line_wr_ctrl
// Directed bench for mfhwt_line_wr_ctrl with LINE_W = 640. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mfhwt_line_wr_ctrl;
    localparam int LINE_W = 640;
    localparam int GROUP  = 4 * LINE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mfhwt_line_wr_ctrl_if bus ();
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
    logic ovf;
`endif

    mfhwt_line_wr_ctrl #(.LINE_W(LINE_W), .CNT_W(10)) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
        ,
        .oOverflow (ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    int m_row  = 0;
    int m_col  = 0;

    task automatic idle_inputs();
        bus.iValid   = 1'b0;
        bus.iSof     = 1'b0;
        bus.iData    = 16'h0000;
        bus.iFull    = 4'b0000;
        bus.iEmpty   = 1'b1;
        bus.iDsReady = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        m_row = 0;
        m_col = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Push n pixels back to back; the bench tracks row/col on its own.
    task automatic push_pixels(input int n, input bit sof_first, input bit full_r2, input int dseed);
        int   prow, pcol;
        bit   last;
        logic [15:0] d;
        logic [3:0]  full, exp;
        last = 1'b0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bus.oReady !== 1'b1) begin
                errors++;
                $display("FAIL ready_fill pix=%0d got=%b exp=1", i, bus.oReady);
            end
            prow = (sof_first && i == 0) ? 0 : m_row;
            pcol = (sof_first && i == 0) ? 0 : m_col;
            d    = 16'(dseed + i) ^ 16'h5A3C;
            full = (full_r2 && prow == 2) ? 4'b0100 : 4'b0000;
            exp  = full[prow] ? 4'b0000 : (4'b0001 << prow);
            bus.iValid = 1'b1;
            bus.iSof   = sof_first && (i == 0);
            bus.iData  = d;
            bus.iFull  = full;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.oWrreq !== exp) begin
                errors++;
                $display("FAIL wrreq pix=%0d got=%b exp=%b", i, bus.oWrreq, exp);
            end
            checks++;
            if (bus.oData !== d) begin
                errors++;
                $display("FAIL data pix=%0d got=%h exp=%h", i, bus.oData, d);
            end
            last = (prow == 3) && (pcol == LINE_W - 1);
            if (pcol == LINE_W - 1) begin
                m_col = 0;
                m_row = (prow + 1) % 4;
            end else begin
                m_col = pcol + 1;
                m_row = prow;
            end
        end
        idle_inputs();
        checks++;
        if (bus.oReady !== (last ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL ready_after_push got=%b exp=%b", bus.oReady, !last);
        end
    endtask

    // Drain one group; iValid is held high to show it is ignored. stop > 0
    // returns right after that many reads have been issued.
    task automatic drain_group(input bit toggle, input int stop);
        int rd_cnt, cv_cnt, gd_cnt;
        bit prev_rd, prev_cv, rd, cv, done;
        rd_cnt = 0; cv_cnt = 0; gd_cnt = 0;
        prev_rd = 1'b0; prev_cv = 1'b0; done = 1'b0;
        for (int c = 0; c < GROUP && !done; c++) begin
            if (c > 0) begin
                checks++;
                if (bus.oWrreq !== 4'b0000) begin
                    errors++;
                    $display("FAIL wrreq_drain cyc=%0d got=%b exp=0000", c, bus.oWrreq);
                end
            end
            checks++;
            if (bus.oColValid !== prev_rd) begin
                errors++;
                $display("FAIL colvalid cyc=%0d got=%b exp=%b", c, bus.oColValid, prev_rd);
            end
            cv = bus.oColValid;
            if (cv) cv_cnt++;
            if (bus.oGroupDone === 1'b1) begin
                gd_cnt++;
                done = 1'b1;
                checks++;
                if (!(prev_cv && cv_cnt == LINE_W)) begin
                    errors++;
                    $display("FAIL gd_timing prev_colvalid=%b colvalids=%0d exp=1/%0d", prev_cv, cv_cnt, LINE_W);
                end
                checks++;
                if (bus.oReady !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_back got=%b exp=1", bus.oReady);
                end
            end else begin
                checks++;
                if (bus.oReady !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_drain cyc=%0d got=%b exp=0", c, bus.oReady);
                end
                bus.iValid   = 1'b1;
                bus.iData    = 16'hDEAD;
                bus.iEmpty   = 1'b0;
                bus.iDsReady = toggle ? (((c / 3) % 2) == 0) : 1'b1;
                #1;
                rd = bus.oRdreq;
                if (rd) rd_cnt++;
                prev_rd = rd;
                prev_cv = cv;
                @(posedge clk);
                @(negedge clk);
                if (stop > 0 && rd_cnt == stop) begin
                    idle_inputs();
                    return;
                end
            end
        end
        idle_inputs();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL gd_seen got=0 exp=1 (timeout)");
        end
        checks++;
        if (rd_cnt != LINE_W) begin
            errors++;
            $display("FAIL rdreq_count got=%0d exp=%0d", rd_cnt, LINE_W);
        end
        checks++;
        if (cv_cnt != LINE_W) begin
            errors++;
            $display("FAIL colvalid_count got=%0d exp=%0d", cv_cnt, LINE_W);
        end
        checks++;
        if (gd_cnt != 1) begin
            errors++;
            $display("FAIL gd_count got=%0d exp=1", gd_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.oGroupDone !== 1'b0 || bus.oReady !== 1'b1 || bus.oColValid !== 1'b0) begin
            errors++;
            $display("FAIL post_drain gd=%b ready=%b colvalid=%b exp=0/1/0", bus.oGroupDone, bus.oReady, bus.oColValid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.iDsReady = 1'b1;
        bus.iEmpty   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.oRdreq !== 1'b0) begin
            errors++;
            $display("FAIL rst_rdreq got=%b exp=0", bus.oRdreq);
        end
        checks++;
        if (bus.oWrreq !== 4'b0000 || bus.oData !== 16'h0000) begin
            errors++;
            $display("FAIL rst_wr wrreq=%b data=%h exp=0000/0000", bus.oWrreq, bus.oData);
        end
        checks++;
        if (bus.oColValid !== 1'b0 || bus.oGroupDone !== 1'b0 || bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_ctl colvalid=%b gd=%b ready=%b exp=0/0/1", bus.oColValid, bus.oGroupDone, bus.oReady);
        end
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_ovf got=%b exp=0", ovf);
        end
`endif
        do_reset();
    endtask

    task automatic test_fill_drain();
        do_reset();
        push_pixels(GROUP, 1'b0, 1'b0, 0);
        drain_group(1'b0, 0);
    endtask

    task automatic test_back_to_back();
        push_pixels(GROUP, 1'b0, 1'b0, 1000);
        drain_group(1'b1, 0);
        push_pixels(1, 1'b0, 1'b0, 77);
        checks++;
        if (bus.oWrreq !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_first got=%b exp=0001", bus.oWrreq);
        end
        do_reset();
    endtask

    task automatic test_sof();
        do_reset();
        push_pixels(900, 1'b0, 1'b0, 0);
        push_pixels(1, 1'b1, 1'b0, 900);
        checks++;
        if (bus.oWrreq !== 4'b0001) begin
            errors++;
            $display("FAIL sof_wrreq got=%b exp=0001", bus.oWrreq);
        end
        push_pixels(GROUP - 1, 1'b0, 1'b0, 901);
        drain_group(1'b0, 0);
    endtask

    task automatic test_full();
        do_reset();
        push_pixels(2 * LINE_W, 1'b0, 1'b1, 5);
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got=%b exp=0", ovf);
        end
`endif
        push_pixels(2 * LINE_W, 1'b0, 1'b1, 5 + 2 * LINE_W);
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got=%b exp=1", ovf);
        end
`endif
        drain_group(1'b0, 0);
`ifdef MFHWT_LINE_WR_CTRL_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=1", ovf);
        end
        do_reset();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=0", ovf);
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        push_pixels(GROUP, 1'b0, 1'b0, 3);
        drain_group(1'b0, 300);
        bus.iDsReady = 1'b1;
        bus.iEmpty   = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.oRdreq !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_rdreq got=%b exp=0", bus.oRdreq);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        #1;
        checks++;
        if (bus.oRdreq !== 1'b0 || bus.oColValid !== 1'b0 || bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_state rdreq=%b colvalid=%b ready=%b exp=0/0/1", bus.oRdreq, bus.oColValid, bus.oReady);
        end
        idle_inputs();
        push_pixels(1, 1'b0, 1'b0, 11);
        checks++;
        if (bus.oWrreq !== 4'b0001) begin
            errors++;
            $display("FAIL mid_rst_first got=%b exp=0001", bus.oWrreq);
        end
        push_pixels(GROUP - 1, 1'b0, 1'b0, 12);
        drain_group(1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_sof();
        test_full();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mfhwt_line_wr_ctrl.md
MFHWT_LINE_WR_CTRL -- requirements
Module: mfhwt_line_wr_ctrl

Interface
REQ-001 Parameter LINE_W, default 640: pixels per image row and depth of each line FIFO.
REQ-002 Parameter CNT_W, default 10: width of the column counter; SHALL satisfy 2^CNT_W >= LINE_W.
REQ-003 Port iClk, input, 1: single clock; every register is rising-edge.
REQ-004 Port iReset, input, 1: reset, synchronous and active-high.
REQ-005 Port iValid, input, 1: pixel on iData is valid this cycle.
REQ-006 Port iSof, input, 1: start of frame; qualified by iValid.
REQ-007 Port iData, input, 16: pixel data.
REQ-008 Port oReady, output, 1: block accepts a pixel this cycle.
REQ-009 Port oWrreq, output, 4: one-hot write request to the 4-row line FIFO bank.
REQ-010 Port oData, output, 16: write data to the FIFO bank.
REQ-011 Port iFull, input, 4: per-row FIFO full flags.
REQ-012 Port iEmpty, input, 1: FIFO bank all-empty flag.
REQ-013 Port oRdreq, output, 1: common read request to all 4 FIFOs.
REQ-014 Port iDsReady, input, 1: downstream stage can take a 4-row column.
REQ-015 Port oColValid, output, 1: 64-bit FIFO output holds a valid 4-row column this cycle.
REQ-016 Port oGroupDone, output, 1: one-cycle pulse when a 4-row group is fully drained.

Function
REQ-017 The FSM SHALL have two states: FILL and DRAIN.
REQ-018 In FILL, oReady SHALL be 1. In DRAIN, oReady SHALL be 0.
REQ-019 A pixel SHALL be accepted when iValid && oReady.
REQ-020 On accept, oWrreq SHALL be registered as (1 << row) and oData as iData, both one cycle after accept; oWrreq SHALL be 0 in every other cycle.
REQ-021 On accept, col SHALL increment; at col == LINE_W-1 col SHALL wrap to 0 and row SHALL increment, mod 4.
REQ-022 Accepting pixel (row 3, col LINE_W-1) SHALL transition FILL to DRAIN.
REQ-023 Accepted iSof SHALL force the pixel into (row 0, col 0); the next pixel goes to (row 0, col 1). A partial group is discarded logically; the FIFOs are not flushed.
REQ-024 In DRAIN, oRdreq SHALL be combinational iDsReady && !iEmpty && (rdcnt < LINE_W).
REQ-025 rdcnt SHALL increment on each oRdreq and SHALL reset to 0 on entering DRAIN.
REQ-026 oColValid SHALL equal oRdreq delayed by one cycle (registered FIFO output latency).
REQ-027 DRAIN SHALL exit to FILL on the cycle after the last oColValid (rdcnt == LINE_W, no read pending), with row = col = 0.
REQ-028 oGroupDone SHALL pulse for 1 cycle on the DRAIN-to-FILL transition.
REQ-029 A write SHALL NOT be issued when iFull[row] == 1 at accept. The pixel is dropped, but col and row still advance.
REQ-030 iDsReady deassertion mid-drain SHALL stall reads without losing count; reads resume when it returns high.
REQ-031 iValid in DRAIN SHALL be ignored; no counter changes.

Reset
REQ-032 While iReset is high at a clock edge, the block SHALL set: state = FILL, row = col = rdcnt = 0, oWrreq = 0, oData = 0, oColValid = 0, oGroupDone = 0.
REQ-033 During reset, oRdreq SHALL be 0.
REQ-034 Reset SHALL take effect in any state, including mid-DRAIN; the FIFO contents are the upstream owner's concern.

Configuration
REQ-035 With macro MFHWT_LINE_WR_CTRL_OVF_EN defined, the block SHALL add output oOverflow (1 bit).
REQ-036 oOverflow SHALL be set sticky on any write dropped per REQ-029, and cleared only by iReset.
REQ-037 Without MFHWT_LINE_WR_CTRL_OVF_EN, oOverflow and its register SHALL NOT exist; drop behaviour is otherwise identical.

Verification
REQ-038 Reset, then 2560 continuous valid pixels with LINE_W=640 -> oWrreq goes 0001 x640, 0010 x640, 0100 x640, 1000 x640, each one cycle after accept; oReady drops after pixel 2559.
REQ-039 DRAIN with iDsReady=1 and iEmpty=0 -> exactly 640 oRdreq cycles; oColValid follows 1 cycle later; oGroupDone pulses once; oReady returns 1.
REQ-040 Toggle iDsReady 1/0 every 3 cycles in DRAIN -> still exactly 640 oColValid, no duplicates, and oGroupDone fires after the last one.
REQ-041 iSof at pixel 900 (row 1, col 260) -> that pixel is written with oWrreq=0001, and the next DRAIN begins after 2560 further-counted pixels from the iSof pixel.
REQ-042 iFull=0100 held during row 2 with OVF_EN defined -> no oWrreq[2] pulses, counters still reach DRAIN, oOverflow=1 until reset; without OVF_EN, same oWrreq behaviour and the port is absent.
REQ-043 iReset at rdcnt=300 -> next cycle: state FILL, oRdreq=0, oColValid=0, oReady=1, and the first accepted pixel gives oWrreq=0001.
